// File: rtl/param_register_file_pkg.sv
// -----------------------------------------------------------------------------
// param_register_file_pkg
// Shared definitions for the parametrised register file: the sequencer state
// encoding, the post-reset content modes and the helper that turns an entry
// index into its post-reset value.
// -----------------------------------------------------------------------------
package param_register_file_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int INIT_MODE_ZERO  = 0;
    localparam int INIT_MODE_INDEX = 1;

    // DEPTH never exceeds 256, so every index fits in this many bits.
    localparam int IDX_W = 8;

    // Value loaded into an entry by the sequencer; callers zero-extend or
    // truncate to the data width.
    function automatic logic [IDX_W-1:0] init_value(input logic [IDX_W-1:0] idx,
                                                    input int mode);
        return (mode == INIT_MODE_INDEX) ? idx : '0;
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// -----------------------------------------------------------------------------
// param_register_file_if
// Datapath-side bus of the register file.
//   RA     packed read addresses, port k at [k*AW +: AW]
//   BusR   packed read data, port k at [k*WIDTH +: WIDTH]
//   RW     write address
//   BusW   write data
//   RegWr  write enable
//   Ready  high once the post-reset initialisation has finished
// master = datapath (decode/writeback), slave = register file.
// -----------------------------------------------------------------------------
interface param_register_file_if #(
    parameter int WIDTH = 64,
    parameter int NREAD = 2,
    parameter int AW    = 5
) ();

    logic [NREAD*AW-1:0]    RA;
    logic [NREAD*WIDTH-1:0] BusR;
    logic [AW-1:0]          RW;
    logic [WIDTH-1:0]       BusW;
    logic                   RegWr;
    logic                   Ready;

    modport master (
        output RA, RW, BusW, RegWr,
        input  BusR, Ready
    );

    modport slave (
        input  RA, RW, BusW, RegWr,
        output BusR, Ready
    );

endinterface

// File: rtl/param_register_file_init_seq.sv
// -----------------------------------------------------------------------------
// param_register_file_init_seq
// Post-reset initialisation sequencer. After reset it walks entries
// 0..DEPTH-1, one per cycle, presenting a write of the init value, then moves
// to RUN and raises ready.
//   Clk, Reset  clock and synchronous active-high reset
//   ready       registered, high while in RUN
//   init_we     write request for the current init entry
//   init_addr   entry being initialised
//   init_data   value for that entry (zero for the hardwired-zero register)
// -----------------------------------------------------------------------------
module param_register_file_init_seq
    import param_register_file_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 64,
    parameter int ZERO_REG  = DEPTH - 1,
    parameter int INIT_MODE = INIT_MODE_INDEX,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic             ready,
    output logic             init_we,
    output logic [AW-1:0]    init_addr,
    output logic [WIDTH-1:0] init_data
);

    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    state_e                 state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic [WIDTH+IDX_W-1:0] value_ext;

    // Next state: one init write per cycle, leave INIT after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (cnt_q == LAST_A) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Widen before truncating so narrow data widths still take the low bits.
    always_comb begin
        value_ext = {{WIDTH{1'b0}}, init_value(IDX_W'(cnt_q), INIT_MODE)};
        init_data = (cnt_q == ZERO_A) ? '0 : value_ext[WIDTH-1:0];
    end

    assign init_addr = cnt_q;
    assign ready     = ready_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// Parametrised register file between decode and the ALU: NREAD combinational
// read ports with same-cycle write bypass, one write port, a hardwired-zero
// register and a post-reset initialisation sequencer.
//   Clk, Reset  clock and synchronous active-high reset
//   bus         slave side of param_register_file_if (RA, BusR, RW, BusW,
//               RegWr, Ready)
// -----------------------------------------------------------------------------
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int NREAD     = 2,
    parameter int ZERO_REG  = DEPTH - 1,
    parameter int INIT_MODE = INIT_MODE_INDEX,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    param_register_file_if.slave  bus
);

    localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);
    localparam logic [AW:0]   DEPTH_E = (AW + 1)'(DEPTH);

    logic                   ready;
    logic                   init_we;
    logic [AW-1:0]          init_addr;
    logic [WIDTH-1:0]       init_data;
    logic                   dp_wr_legal;
    logic                   wr_en_d;
    logic [AW-1:0]          wr_addr_d;
    logic [WIDTH-1:0]       wr_data_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [NREAD*WIDTH-1:0] bus_r;

    param_register_file_init_seq #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ZERO_REG  (ZERO_REG),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .Clk       (Clk),
        .Reset     (Reset),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // A datapath write only lands on a real, writable entry; this same
    // condition qualifies the bypass so illegal writes are never forwarded.
    assign dp_wr_legal = bus.RegWr && ({1'b0, bus.RW} < DEPTH_E) && (bus.RW != ZERO_A);

    // The sequencer owns the write port until ready; datapath writes in INIT
    // are simply dropped.
    always_comb begin
        wr_en_d   = dp_wr_legal;
        wr_addr_d = bus.RW;
        wr_data_d = bus.BusW;
        if (!ready) begin
            wr_en_d   = init_we;
            wr_addr_d = init_addr;
            wr_data_d = init_data;
        end
    end

    // Storage is deliberately not reset; the sequencer rewrites every entry.
    always_ff @(posedge Clk) begin
        if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    // One read/bypass mux per port; zero while initialising, for the zero
    // register and for addresses past the end of the array.
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] ra;
        logic          ra_legal;

        assign ra       = bus.RA[k*AW +: AW];
        assign ra_legal = ({1'b0, ra} < DEPTH_E) && (ra != ZERO_A);
        assign bus_r[k*WIDTH +: WIDTH] =
            (!ready || !ra_legal)           ? '0       :
            (dp_wr_legal && bus.RW == ra)   ? bus.BusW :
                                              mem_q[ra];
    end

    assign bus.BusR  = bus_r;
    assign bus.Ready = ready;

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the single-cycle datapath register file: configurable data width, register count and read-port count, with an explicit hardwired-zero register, same-cycle write-to-read bypass, and a post-reset initialisation sequencer. It sits between decode and the ALU, supplying operands on its read buses and accepting the writeback result on BusW. The sequencer loads a known pattern into every entry after reset, then raises Ready; the datapath stalls until Ready is high.

## Interface
Parameters:
- WIDTH, 64, data width of every register and bus
- DEPTH, 32, number of registers (2..256, need not be a power of two)
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, DEPTH-1, index of the hardwired-zero register
- INIT_MODE, 1, post-reset contents: 0 = all zero, 1 = entry i holds value i
- AW (localparam), $clog2(DEPTH), address width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- RA  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- BusR  out  NREAD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]
- RW  in  AW  write address
- BusW  in  WIDTH  write data
- RegWr  in  1  write enable
- Ready  out  1  high once initialisation is complete

## Operation
- States: INIT, RUN. Reset (sampled at a rising edge) forces INIT, init counter = 0, Ready = 0, regardless of current state or an in-flight init.
- INIT: each cycle writes the init value (0, or counter zero-extended to WIDTH per INIT_MODE) to entry[counter], then counter+1. After the write of entry DEPTH-1, next state RUN. INIT lasts exactly DEPTH cycles. ZERO_REG entry is always written 0.
- INIT: RegWr ignored; every BusR port reads 0.
- RUN: if RegWr, RW < DEPTH and RW != ZERO_REG, entry[RW] <= BusW at the rising edge. Otherwise no state change.
- Read (RUN), per port k, combinational, priority order:
  - RA_k == ZERO_REG or RA_k >= DEPTH -> 0
  - RegWr && RW == RA_k (write legal) -> BusW (bypass, same cycle)
  - else entry[RA_k]
- Multiple ports reading the same address, including the write address, all see identical data.
- Ready = (state == RUN), registered; no other outputs are stateful.

## Timing
- Reset values: Ready = 0, state = INIT, counter = 0; BusR = 0 throughout INIT. Array contents are not cleared by Reset itself, only by the sequencer.
- Ready rises in the cycle after the DEPTH-th init write, i.e. DEPTH cycles after the last cycle with Reset high.
- Read latency 0 cycles (combinational from RA, RW, BusW, RegWr). Write latency 1 edge; bypass makes the written value visible in the same cycle.
- No handshake on RegWr: a write in RUN is always accepted. Writes in INIT are dropped, not queued.
- Reset asserted mid-INIT restarts the counter at 0; reset asserted in RUN discards contents via re-init.

## Structure
- Shared package regfile_pkg: state enum (INIT, RUN), INIT_MODE encodings, and a function computing the init value from index and mode.
- One sub-module is natural: regfile_init_seq (state register, counter, Ready, init write address/data/enable). The top muxes its write port with the datapath write port and instantiates NREAD copies of the read/bypass logic in a generate loop.

## Test plan
- Reset 1 cycle, defaults: Ready low for exactly 32 cycles, then high; read RA0=5, RA1=30 -> BusR 5 and 30; RA0=31 -> 0.
- RUN, RegWr=1, RW=7, BusW=64'hDEAD_BEEF, RA0=7 same cycle -> BusR0 = DEAD_BEEF (bypass); next cycle RegWr=0 -> still DEAD_BEEF.
- RegWr=1, RW=31 (ZERO_REG), BusW=all ones; RA0=31 same and next cycle -> 0.
- During INIT: RegWr=1, RW=3, BusW=99 -> BusR reads 0; after Ready, RA0=3 -> 3 (write dropped).
- Reset reasserted at init cycle 10 -> Ready stays low 32 more cycles; earlier RUN write to entry 7 gone, reads 7.
- DEPTH=20, NREAD=3, WIDTH=16, INIT_MODE=0: Ready after 20 cycles; RA=25 -> 0, write to RW=25 ignored; three ports all read RW=4 with RegWr=1, BusW=16'h1234 -> all three 1234.
